// File: rtl/s_16bit_unfold_pkg.sv
// Shared widths and the reconstructed {a,b} pair type for the 16-bit unfold block.
package s_16bit_unfold_pkg;
    localparam int BYTE_W = 8;
    localparam int WORD_W = 16;

    typedef struct packed {
        logic [WORD_W-1:0] a;
        logic [WORD_W-1:0] b;
    } pair_t;
endpackage

// File: rtl/s_unfold_fifo.sv
// DEPTH-entry in-order FIFO; ready is registered so it never depends on pop combinationally.
module s_unfold_fifo
    import s_16bit_unfold_pkg::*;
#(
    parameter int  DEPTH = 2,
    parameter type T     = pair_t
) (
    input  logic clk,
    input  logic rst_n,
    input  logic push,
    input  T     din,
    output logic ready,
    input  logic pop,
    output T     dout,
    output logic valid
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    T               mem [DEPTH];
    logic [PW-1:0]  wr_ptr;
    logic [PW-1:0]  rd_ptr;
    logic [CW-1:0]  occ;
    logic [CW-1:0]  occ_next;
    logic           wr_en;
    logic           rd_en;

    // A full FIFO drops the push even when a pop frees a slot on the same edge.
    assign wr_en = push && ready;
    assign rd_en = pop && valid;
    assign valid = (occ != '0);
    assign dout  = valid ? mem[rd_ptr] : '0;

    always_comb begin
        occ_next = occ;
        case ({wr_en, rd_en})
            2'b10:   occ_next = occ + CW'(1);
            2'b01:   occ_next = occ - CW'(1);
            default: occ_next = occ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            occ    <= '0;
            ready  <= 1'b0;
        end else begin
            occ   <= occ_next;
            ready <= (occ_next < CW'(DEPTH));
            if (wr_en) wr_ptr <= (wr_ptr == PW'(DEPTH - 1)) ? '0 : wr_ptr + PW'(1);
            if (rd_en) rd_ptr <= (rd_ptr == PW'(DEPTH - 1)) ? '0 : rd_ptr + PW'(1);
        end
    end

    // Storage needs no reset: the head is masked to zero whenever the FIFO is empty.
    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr] <= din;
    end
endmodule

// File: rtl/s_16bit_unfold.sv
// Rebuilds 16-bit words A/B from folded bytes plus high-byte keys and buffers them.
module s_16bit_unfold
    import s_16bit_unfold_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [BYTE_W-1:0] aa,
    input  logic [BYTE_W-1:0] bb,
    input  logic [BYTE_W-1:0] ka,
    input  logic [BYTE_W-1:0] kb,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [WORD_W-1:0] a,
    output logic [WORD_W-1:0] b,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [WORD_W-1:0] word_cnt
);
    pair_t din;
    pair_t dout;

    assign din.a = {ka, aa ^ ka};
    assign din.b = {kb, bb ^ kb};

    s_unfold_fifo #(
        .DEPTH (DEPTH),
        .T     (pair_t)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (in_valid),
        .din   (din),
        .ready (in_ready),
        .pop   (out_ready),
        .dout  (dout),
        .valid (out_valid)
    );

    assign a = dout.a;
    assign b = dout.b;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                      word_cnt <= '0;
        else if (out_valid && out_ready) word_cnt <= word_cnt + 16'd1;
    end
endmodule

// File: doc/s_16bit_unfold.md
S_16BIT_UNFOLD -- requirements
Module: s_16bit_unfold

Interface
REQ-001 SHALL have parameter DEPTH, default 2, meaning output buffer depth in words (legal values 2 or 4).
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-004 SHALL have port aa, input, 8 bits: folded word A (A low byte XOR A high byte).
REQ-005 SHALL have port bb, input, 8 bits: folded word B.
REQ-006 SHALL have port ka, input, 8 bits: key for A, equal to the original A[15:8].
REQ-007 SHALL have port kb, input, 8 bits: key for B, equal to the original B[15:8].
REQ-008 SHALL have port in_valid, input, 1 bit: aa/bb/ka/kb are valid this cycle.
REQ-009 SHALL have port in_ready, output, 1 bit: the block accepts input this cycle.
REQ-010 SHALL have port a, output, 16 bits: reconstructed word A.
REQ-011 SHALL have port b, output, 16 bits: reconstructed word B.
REQ-012 SHALL have port out_valid, output, 1 bit: a/b are valid.
REQ-013 SHALL have port out_ready, input, 1 bit: the consumer accepts a/b.
REQ-014 SHALL have port word_cnt, output, 16 bits: number of words delivered.

Function
REQ-015 Reconstruction SHALL be a = {ka, aa ^ ka} and b = {kb, bb ^ kb}, computed on the accept cycle.
REQ-016 An input transfer SHALL occur when in_valid and in_ready are both high on a rising clk edge.
REQ-017 An output transfer SHALL occur when out_valid and out_ready are both high on a rising clk edge.
REQ-018 Reconstructed {a,b} pairs SHALL be written into a DEPTH-entry FIFO and delivered in order.
REQ-019 in_ready SHALL equal (occupancy < DEPTH), registered, with no combinational path from out_ready.
REQ-020 out_valid SHALL equal (occupancy != 0); a/b SHALL be driven from the FIFO head.
REQ-021 Latency SHALL be 1 cycle: input accepted at edge N into an empty FIFO gives out_valid high after edge N.
REQ-022 Simultaneous push and pop SHALL leave occupancy unchanged and preserve ordering, including when occupancy is DEPTH-1.
REQ-023 When full, in_ready SHALL be low and inputs SHALL be ignored, even if a pop occurs in the same cycle; in_ready rises the cycle after the pop.
REQ-024 a/b SHALL hold stable while out_valid is high and out_ready is low.
REQ-025 Read and write pointers SHALL wrap modulo DEPTH.
REQ-026 word_cnt SHALL increment by 1 per output transfer and wrap from 0xFFFF to 0x0000.
REQ-027 Inputs SHALL be ignored while in_valid is low, regardless of their values.

Reset
REQ-028 While rst_n is low, the block SHALL immediately force out_valid=0, in_ready=0, a=0, b=0, word_cnt=0, pointers=0 and occupancy=0.
REQ-029 in_ready SHALL rise on the first clk edge after rst_n deasserts.
REQ-030 A reset mid-stream SHALL discard all buffered words; no partial words SHALL appear afterward.

Structure
REQ-031 A shared package SHALL hold the byte width (8), the word width (16) and the typedef for the {a,b} pair.
REQ-032 The FIFO SHALL be a single sub-module named s_unfold_fifo, parameterised by DEPTH and the pair type.

Verification
REQ-033 aa=0x00, ka=0xAB, bb=0xFF, kb=0x0F, one beat, out_ready=1 -> next cycle a=0xABAB, b=0x0FF0, out_valid=1, then word_cnt=1.
REQ-034 DEPTH=2, out_ready=0, three consecutive in_valid beats -> first two accepted, in_ready=0 on the third; release out_ready -> the two words emerge in order, then the third is accepted.
REQ-035 Full FIFO with push and pop in the same cycle -> push ignored, occupancy=DEPTH-1, in_ready=1 the next cycle.
REQ-036 Continuous streaming with out_ready=1, 0x10000 beats -> word_cnt wraps to 0x0000, no stall after the first fill.
REQ-037 rst_n pulsed low with 2 words buffered -> out_valid=0 and word_cnt=0 immediately; no stale word after reset.
REQ-038 Random folded inputs generated as aa = x[7:0] ^ x[15:8], with scoreboard comparison against x, and random out_ready -> zero mismatches over 10k words.
